// File: rtl/boid_frame_plotter.sv
// Per-frame boid sprite plotter: swaps display buffers, walks each boid, and writes a clipped square sprite to the display RAM.
// Optional feature macro: BOID_PLOT_STATS_EN (count plotted boids into boids_drawn).
module boid_frame_plotter #(
    parameter int MAX_BOIDS      = 8,
    parameter int BOID_SEL_WIDTH = $clog2(MAX_BOIDS),
    parameter int VIDEO_WIDTH    = 640,
    parameter int VIDEO_HEIGHT   = 480,
    parameter int ADDR_WIDTH     = 19,
    parameter int SPRITE_SIZE    = 2
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      frame_start,
    output logic [BOID_SEL_WIDTH-1:0] boid_sel,
    input  logic [9:0]                boid_x,
    input  logic [8:0]                boid_y,
    output logic                      buf_swap,
    output logic                      pix_we,
    output logic [ADDR_WIDTH-1:0]     pix_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun,
    output logic [BOID_SEL_WIDTH:0]   boids_drawn
);
    typedef enum logic [2:0] {S_IDLE, S_SWAP, S_SELECT, S_LATCH, S_PLOT, S_DONE} state_t;

    localparam int DW = 3;
    localparam logic [DW-1:0]             LAST_D   = DW'(SPRITE_SIZE - 1);
    localparam logic [BOID_SEL_WIDTH-1:0] LAST_IDX = BOID_SEL_WIDTH'(MAX_BOIDS - 1);
    localparam logic [ADDR_WIDTH-1:0]     ROW_STEP = ADDR_WIDTH'(VIDEO_WIDTH);
    localparam logic [10:0]               VW_X     = 11'(VIDEO_WIDTH);
    localparam logic [9:0]                VH_Y     = 10'(VIDEO_HEIGHT);

    state_t                    state_q, state_d;
    logic [BOID_SEL_WIDTH-1:0] idx_q, idx_d;
    logic [9:0]                x_q, x_d;
    logic [8:0]                y_q, y_d;
    logic [DW-1:0]             dx_q, dx_d, dy_q, dy_d;
    logic [ADDR_WIDTH-1:0]     row_base_q, row_base_d;

    logic                      buf_swap_q, pix_we_q, busy_q, done_q, overrun_q, fs_ign_q;
    logic [ADDR_WIDTH-1:0]     pix_addr_q;
    logic [BOID_SEL_WIDTH-1:0] boid_sel_q;

    logic        on_screen, last_boid, pix_in;
    logic [10:0] px;
    logic [9:0]  py;

    assign on_screen = ({1'b0, boid_x} < VW_X) && ({1'b0, boid_y} < VH_Y);
    assign last_boid = (idx_q == LAST_IDX);
    assign px        = {1'b0, x_q} + 11'(dx_q);
    assign py        = {1'b0, y_q} + 10'(dy_q);
    assign pix_in    = (px < VW_X) && (py < VH_Y);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        x_d        = x_q;
        y_d        = y_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        row_base_d = row_base_q;
        case (state_q)
            S_IDLE: begin
                if (frame_start) state_d = S_SWAP;
            end
            S_SWAP: begin
                idx_d   = '0;
                state_d = S_SELECT;
            end
            S_SELECT: state_d = S_LATCH;
            S_LATCH: begin
                x_d = boid_x;
                y_d = boid_y;
                if (on_screen) begin
                    row_base_d = ADDR_WIDTH'(boid_y) * ROW_STEP + ADDR_WIDTH'(boid_x);
                    dx_d       = '0;
                    dy_d       = '0;
                    state_d    = S_PLOT;
                end else if (last_boid) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_SELECT;
                end
            end
            S_PLOT: begin
                if (dx_q == LAST_D) begin
                    dx_d       = '0;
                    row_base_d = row_base_q + ROW_STEP;
                    if (dy_q == LAST_D) begin
                        if (last_boid) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_SELECT;
                        end
                    end else begin
                        dy_d = dy_q + 1'b1;
                    end
                end else begin
                    dx_d = dx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            row_base_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            row_base_q <= row_base_d;
        end
    end

    // Every output is a register fed from the current state, so nothing combinational reaches a port.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            buf_swap_q <= 1'b0;
            pix_we_q   <= 1'b0;
            pix_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fs_ign_q   <= 1'b0;
            overrun_q  <= 1'b0;
            boid_sel_q <= '0;
        end else begin
            buf_swap_q <= (state_q == S_SWAP);
            busy_q     <= (state_q != S_IDLE);
            done_q     <= (state_q == S_DONE);
            pix_we_q   <= (state_q == S_PLOT) && pix_in;
            if (state_q == S_PLOT) pix_addr_q <= row_base_q + ADDR_WIDTH'(dx_q);
            if (state_q == S_IDLE)        boid_sel_q <= '0;
            else if (state_q == S_SELECT) boid_sel_q <= idx_q;
            fs_ign_q   <= frame_start && (state_q != S_IDLE);
            overrun_q  <= fs_ign_q;
        end
    end

`ifdef BOID_PLOT_STATS_EN
    logic [BOID_SEL_WIDTH:0] cnt_q, drawn_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            drawn_q <= '0;
        end else begin
            if (state_q == S_SWAP)                    cnt_q <= '0;
            else if (state_q == S_LATCH && on_screen) cnt_q <= cnt_q + 1'b1;
            if (state_q == S_DONE) drawn_q <= cnt_q;
        end
    end

    assign boids_drawn = drawn_q;
`else
    assign boids_drawn = '0;
`endif

    assign buf_swap = buf_swap_q;
    assign pix_we   = pix_we_q;
    assign pix_addr = pix_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;
    assign boid_sel = boid_sel_q;
endmodule

// File: tb/tb_boid_frame_plotter.sv
// Randomized and directed frames checked cycle by cycle against a timeline model of the plotter.
module tb_boid_frame_plotter;
    localparam int MAXB = 8;
    localparam int SPR  = 2;
    localparam int VW   = 640;
    localparam int VH   = 480;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_start = 1'b0;
    logic [2:0]  boid_sel;
    logic [9:0]  boid_x;
    logic [8:0]  boid_y;
    logic        buf_swap, pix_we, busy, done, overrun;
    logic [18:0] pix_addr;
    logic [3:0]  boids_drawn;

    int bx[MAXB];
    int by[MAXB];

    assign boid_x = 10'(bx[boid_sel]);
    assign boid_y = 9'(by[boid_sel]);

    boid_frame_plotter dut (
        .clock(clock), .resetn(resetn), .frame_start(frame_start),
        .boid_sel(boid_sel), .boid_x(boid_x), .boid_y(boid_y),
        .buf_swap(buf_swap), .pix_we(pix_we), .pix_addr(pix_addr),
        .busy(busy), .done(done), .overrun(overrun), .boids_drawn(boids_drawn)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cur_c    = 0;
    int last_writes;

    int exp_we[256];
    int exp_addr[256];
    int exp_sel[256];
    int exp_ovr[256];
    int done_c, exp_drawn, exp_writes;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cur_c, act, exp);
    endtask

    // Timeline of one frame: SWAP in cycle 1, then per boid SELECT+LATCH and, if on screen, SPR*SPR plot cycles.
    function automatic void build_model(input int oa, input int ob);
        int t, px, py;
        for (int i = 0; i < 256; i++) begin
            exp_we[i] = 0; exp_addr[i] = 0; exp_sel[i] = 0; exp_ovr[i] = 0;
        end
        t = 2; exp_drawn = 0; exp_writes = 0;
        for (int b = 0; b < MAXB; b++) begin
            if (bx[b] >= VW || by[b] >= VH) begin
                t += 2;
            end else begin
                exp_drawn++;
                for (int k = 0; k < SPR * SPR; k++) begin
                    px = bx[b] + k % SPR;
                    py = by[b] + k / SPR;
                    if (px < VW && py < VH) begin
                        exp_we[t + 2 + k]   = 1;
                        exp_addr[t + 2 + k] = py * VW + px;
                        exp_sel[t + 2 + k]  = b;
                        exp_writes++;
                    end
                end
                t += 2 + SPR * SPR;
            end
        end
        done_c = t;
        if (oa > 0) exp_ovr[oa + 1] = 1;
        if (ob > 0) exp_ovr[ob + 1] = 1;
    endfunction

    task automatic run_frame(input int oa, input int ob, input int abort_c);
        int dut_w;
        int ed;
        build_model(oa, ob);
        dut_w = 0;
        @(negedge clock); frame_start = 1'b1;
        @(posedge clock); @(negedge clock); frame_start = 1'b0;
        for (int c = 1; c <= done_c + 2; c++) begin
            frame_start = (c == oa || c == ob);
            @(posedge clock); @(negedge clock);
            frame_start = 1'b0;
            cur_c = c;
            chk("pix_we", int'(pix_we), exp_we[c]);
            if (exp_we[c] != 0) begin
                chk("pix_addr", int'(pix_addr), exp_addr[c]);
                chk("boid_sel", int'(boid_sel), exp_sel[c]);
            end
            chk("buf_swap", int'(buf_swap), int'(c == 1));
            chk("done", int'(done), int'(c == done_c));
            chk("busy", int'(busy), int'(c >= 1 && c <= done_c));
            chk("overrun", int'(overrun), exp_ovr[c]);
            if (c == done_c) begin
`ifdef BOID_PLOT_STATS_EN
                ed = exp_drawn;
`else
                ed = 0;
`endif
                chk("boids_drawn", int'(boids_drawn), ed);
            end
            if (pix_we) dut_w++;
            if (c == abort_c) begin
                #1 resetn = 1'b0;
                #1;
                chk("abort_pix_we", int'(pix_we), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_addr", int'(pix_addr), 0);
                @(negedge clock); @(negedge clock);
                chk("abort_hold_we", int'(pix_we), 0);
                resetn = 1'b1;
                last_writes = dut_w;
                return;
            end
        end
        last_writes = dut_w;
    endtask

    function automatic int rnd_x();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return $urandom_range(VW, 1023);
        if (r == 1) return $urandom_range(VW - 2, VW - 1);
        return $urandom_range(0, VW - 1);
    endfunction

    function automatic int rnd_y();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return $urandom_range(VH, 511);
        if (r == 1) return $urandom_range(VH - 2, VH - 1);
        return $urandom_range(0, VH - 1);
    endfunction

    initial begin
        // Reset held with frame_start high: everything stays quiet.
        resetn = 1'b0; frame_start = 1'b1;
        for (int b = 0; b < MAXB; b++) begin bx[b] = 10; by[b] = 5; end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            cur_c = -1;
            chk("rst_buf_swap", int'(buf_swap), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_pix_we", int'(pix_we), 0);
            chk("rst_outputs", int'({pix_addr, boid_sel, done, overrun, boids_drawn}), 0);
        end
        frame_start = 1'b0; resetn = 1'b1;
        @(negedge clock);

        // All boids at (10,5).
        build_model(0, 0);
        cur_c = -2;
        chk("model_done_c", done_c, 50);
        chk("model_writes", exp_writes, 32);
        chk("model_a4", exp_addr[4], 3210);
        chk("model_a5", exp_addr[5], 3211);
        chk("model_a6", exp_addr[6], 3850);
        chk("model_a7", exp_addr[7], 3851);
        run_frame(0, 0, 0);
        chk("writes_10_5", last_writes, 32);

        // Boid 3 in the bottom-right corner: three of its four pixels clipped.
        for (int b = 0; b < MAXB; b++) begin bx[b] = 100; by[b] = 100; end
        bx[3] = 639; by[3] = 479;
        build_model(0, 0);
        cur_c = -2;
        chk("model_corner_addr", exp_addr[22], 307199);
        chk("model_corner_clip", exp_we[23], 0);
        run_frame(0, 0, 0);
        chk("writes_corner", last_writes, 29);

        // Boids 5 and 6 off screen.
        for (int b = 0; b < MAXB; b++) begin bx[b] = 20; by[b] = 20; end
        bx[5] = 700; by[5] = 10;
        bx[6] = 10;  by[6] = 500;
        build_model(0, 0);
        cur_c = -2;
        chk("model_skip_done", done_c, 42);
        run_frame(0, 0, 0);
        chk("writes_skip", last_writes, 24);

        // Dropped frame_starts mid-frame and in DONE.
        for (int b = 0; b < MAXB; b++) begin
            bx[b] = $urandom_range(0, VW - 1); by[b] = $urandom_range(0, VH - 1);
        end
        run_frame(20, 50, 0);
        cur_c = -2;
        chk("ovr_frame_done", done_c, 50);

        // Reset during PLOT, then a clean full frame.
        run_frame(0, 0, 30);
        for (int b = 0; b < MAXB; b++) begin bx[b] = 10; by[b] = 5; end
        run_frame(0, 0, 0);
        chk("writes_after_abort", last_writes, 32);

        for (int f = 0; f < 20; f++) begin
            for (int b = 0; b < MAXB; b++) begin bx[b] = rnd_x(); by[b] = rnd_y(); end
            if ($urandom_range(0, 1) == 1) run_frame($urandom_range(1, 18), 0, 0);
            else run_frame(0, 0, 0);
            chk("rand_writes", last_writes, exp_writes);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/boid_frame_plotter.md
# boid_frame_plotter

Per-frame sequencer between the Boid Processor Units and the double-buffered boid display RAM. On each end-of-frame pulse from the VGA controller it swaps display buffers, walks every boid through the one-hot boid-select mux, converts each boid's (x, y) into a linear pixel address, and writes a square SPRITE_SIZE×SPRITE_SIZE sprite into the display RAM. Pixels outside the screen are clipped. It replaces the ad-hoc boid counter loop in the top level.

## Interface
Parameters:
- MAX_BOIDS, 8: number of boids walked per frame; must be a power of two and ≥2.
- BOID_SEL_WIDTH, $clog2(MAX_BOIDS): width of the boid select.
- VIDEO_WIDTH, 640: pixels per line.
- VIDEO_HEIGHT, 480: lines per frame.
- ADDR_WIDTH, 19: display RAM address width.
- SPRITE_SIZE, 2: sprite edge in pixels, 1..4.

Ports:
- clock, in, 1: the only clock; all state updates on the rising edge.
- resetn, in, 1: asynchronous, active-low reset.
- frame_start, in, 1: one-cycle end-of-frame pulse (screenEnd_out).
- boid_sel, out, BOID_SEL_WIDTH: boid index driven to the select decoder/tristate mux.
- boid_x, in, 10: x of the selected boid; valid one cycle after boid_sel changes.
- boid_y, in, 9: y of the selected boid; same timing as boid_x.
- buf_swap, out, 1: one-cycle pulse to the display RAM reset/swap input.
- pix_we, out, 1: display RAM write enable. Write data is constant 1.
- pix_addr, out, ADDR_WIDTH: display RAM write address.
- busy, out, 1: high from frame acceptance through DONE.
- done, out, 1: one-cycle pulse when the frame is fully plotted.
- overrun, out, 1: one-cycle pulse when a frame_start is dropped.
- boids_drawn, out, BOID_SEL_WIDTH+1: number of boids plotted in the last completed frame.

## Operation
- States: IDLE, SWAP, SELECT, LATCH, PLOT, DONE.
- IDLE:
  - frame_start=1 moves to SWAP.
  - frame_start is accepted only in IDLE.
- SWAP: buf_swap=1 for one cycle; boid index cleared to 0; go to SELECT.
- SELECT: boid_sel=index; wait one cycle for the mux to settle; go to LATCH.
- LATCH: capture boid_x/boid_y.
  - If x≥VIDEO_WIDTH or y≥VIDEO_HEIGHT, the boid is skipped and control goes to the next boid.
  - Otherwise compute row_base = y*VIDEO_WIDTH + x (constant multiply, ADDR_WIDTH bits, no overflow for legal x,y), clear dx and dy to 0, and go to PLOT.
- PLOT: one candidate pixel per cycle in raster order (dx fastest), SPRITE_SIZE² cycles total.
  - pix_addr = row_base + dx.
  - pix_we = 1 only if (x+dx)<VIDEO_WIDTH and (y+dy)<VIDEO_HEIGHT. Clipped pixels keep pix_we=0; there is no wrap to the next line or to the top.
  - At the end of each row, row_base += VIDEO_WIDTH.
- Next boid: index+1 goes to SELECT. After index MAX_BOIDS-1, go to DONE.
- DONE: done=1 for one cycle, boids_drawn updated, return to IDLE.
- frame_start in any state other than IDLE (DONE included) is ignored and overrun pulses in the following cycle. The frame in progress continues unaffected.
- boid_sel holds its value outside SELECT/LATCH/PLOT; it is 0 in IDLE.
- All outputs are registered; there are no combinational paths from input to output.

## Timing
- Reset (async, resetn=0): state IDLE; boid_sel=0, buf_swap=0, pix_we=0, pix_addr=0, busy=0, done=0, overrun=0, boids_drawn=0. Reset mid-frame aborts immediately with no further writes.
- Cycle 0 is the edge that samples frame_start in IDLE.
  - Cycle 1: buf_swap=1, busy=1.
- Per boid:
  - Plotted: 2 + SPRITE_SIZE² cycles.
  - Skipped: 2 cycles.
- Defaults, all boids on-screen: done is high in cycle 1 + 8×6 + 1 = 50, and busy falls in cycle 51.
- The first pix_we appears in cycle 4, with boid_sel=0 asserted from cycle 2.
- Worst case at SPRITE_SIZE=4 and MAX_BOIDS=8 is 146 cycles, far below a frame period.

## Configuration
- BOID_PLOT_STATS_EN defined: boids_drawn counts plotted (non-skipped) boids during the frame and is loaded in DONE.
- BOID_PLOT_STATS_EN undefined: the counter logic is omitted and boids_drawn is tied to 0. All other behaviour is identical.

## Test plan
- Reset with frame_start held high, resetn=0: all outputs 0, no buf_swap. Then release resetn and pulse frame_start once → buf_swap in cycle 1, done in cycle 50.
- All boids at (10,5), defaults: 32 writes. Boid 0 writes 3210, 3211, 3850, 3851, and every boid writes the same four addresses. boids_drawn=8 when the macro is defined.
- Boid 3 at (639,479): only address 307199 is written. The three clipped cycles have pix_we=0, with no write to 0 or 307200.
- Boid 5 at (700,10) and boid 6 at (10,500): both skipped in 2 cycles each, zero writes for them, done in cycle 42, boids_drawn=6 when the macro is defined.
- frame_start at cycles 20 and 50 (DONE): overrun pulses at cycles 21 and 51. There is no second buf_swap, and the frame still completes at cycle 50.
- resetn asserted at cycle 30 during PLOT: pix_we=0 and busy=0 immediately. After release, a new frame_start produces a full 50-cycle frame.
